dp_ram_arbiter: RTL and testbench



---
 rtl/dp_ram_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_dp_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// dp_ram_arbiter
//
// Purpose:
//   Shares one single-clock dual-port RAM (one write port, one read port with
//   registered read data) between two writers and two readers. The write port
//   and the read port each have their own two-way round-robin arbiter with
//   valid/ready handshakes. Accesses at or beyond DEPTH are accepted but never
//   reach the RAM; they set a sticky error flag, and an out-of-range read still
//   returns a zero response. Read data is routed back to the issuing reader
//   exactly one cycle after its handshake.
//
// Parameters:
//   DW     data width in bits
//   DEPTH  RAM depth in words (need not be a power of two)
//   AW     address width, derived from DEPTH (do not override)
//
// Ports:
//   clk, resetn                 clock (posedge) and asynchronous active-low reset
//   wr0_*/wr1_*                 write requesters: valid, ready, addr, data
//   rd0_valid/rd1_valid         read requests
//   rd0_ready/rd1_ready         read grants (combinational)
//   rd0_addr/rd1_addr           read addresses
//   rd0_rvalid/rd1_rvalid       one pulse per accepted read, 1 cycle later
//   rd0_rdata/rd1_rdata         read data, holds its last value between pulses
//   err                         sticky out-of-range flag, cleared by reset only
//   ram_we, ram_wa, ram_wd      RAM write port
//   ram_re, ram_ra              RAM read port
//   ram_rd                      RAM read data, valid the cycle after ram_re
// -----------------------------------------------------------------------------
module dp_ram_arbiter #(
    parameter int DW    = 18,
    parameter int DEPTH = 360,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          wr0_valid,
    output logic          wr0_ready,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,

    input  logic          wr1_valid,
    output logic          wr1_ready,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,

    input  logic          rd0_valid,
    output logic          rd0_ready,
    input  logic [AW-1:0] rd0_addr,
    output logic          rd0_rvalid,
    output logic [DW-1:0] rd0_rdata,

    input  logic          rd1_valid,
    output logic          rd1_ready,
    input  logic [AW-1:0] rd1_addr,
    output logic          rd1_rvalid,
    output logic [DW-1:0] rd1_rdata,

    output logic          err,

    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_wd,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_rd
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    // Two-way round-robin grant. A lone requester always wins; on contention
    // the requester selected by the pointer wins. Grants are forced low while
    // reset is asserted so nothing handshakes during reset.
    function automatic logic [1:0] rr_grant(input logic [1:0] req,
                                            input logic       ptr,
                                            input logic       run);
        logic [1:0] g;
        g[0] = run && req[0] && (!req[1] || !ptr);
        g[1] = run && req[1] && (!req[0] ||  ptr);
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Requester vectors
    // ------------------------------------------------------------------
    logic [1:0]    w_wr_valid;
    logic [1:0]    w_rd_valid;
    logic [AW-1:0] w_wr_addr [2];
    logic [AW-1:0] w_rd_addr [2];
    logic [1:0]    w_wr_inrange;
    logic [1:0]    w_rd_inrange;

    assign w_wr_valid   = {wr1_valid, wr0_valid};
    assign w_rd_valid   = {rd1_valid, rd0_valid};
    assign w_wr_addr[0] = wr0_addr;
    assign w_wr_addr[1] = wr1_addr;
    assign w_rd_addr[0] = rd0_addr;
    assign w_rd_addr[1] = rd1_addr;

    // Range check is done per requester in a 32-bit domain so that a
    // power-of-two DEPTH (where DEPTH itself does not fit in AW bits) works.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_range
            assign w_wr_inrange[gi] = ({{(32-AW){1'b0}}, w_wr_addr[gi]} < DEPTH_U);
            assign w_rd_inrange[gi] = ({{(32-AW){1'b0}}, w_rd_addr[gi]} < DEPTH_U);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] w_wr_gnt;
    logic [1:0] w_rd_gnt;
    logic       w_wr_any;
    logic       w_rd_any;
    logic       w_wr_win_ok;
    logic       w_rd_win_ok;

    assign w_wr_gnt = rr_grant(w_wr_valid, r_wptr, resetn);
    assign w_rd_gnt = rr_grant(w_rd_valid, r_rptr, resetn);
    assign w_wr_any = |w_wr_gnt;
    assign w_rd_any = |w_rd_gnt;

    assign wr0_ready = w_wr_gnt[0];
    assign wr1_ready = w_wr_gnt[1];
    assign rd0_ready = w_rd_gnt[0];
    assign rd1_ready = w_rd_gnt[1];

    // At most one grant per port, so the winner is simply "granted 1?".
    // When idle the muxes fall through to requester 0.
    assign w_wr_win_ok = w_wr_gnt[1] ? w_wr_inrange[1] : w_wr_inrange[0];
    assign w_rd_win_ok = w_rd_gnt[1] ? w_rd_inrange[1] : w_rd_inrange[0];

    assign ram_we = w_wr_any && w_wr_win_ok;
    assign ram_wa = w_wr_gnt[1] ? wr1_addr : wr0_addr;
    assign ram_wd = w_wr_gnt[1] ? wr1_data : wr0_data;
    assign ram_re = w_rd_any && w_rd_win_ok;
    assign ram_ra = w_rd_gnt[1] ? rd1_addr : rd0_addr;

    // The pointer always moves to the requester that did not win: a grant to
    // 0 points at 1 and vice versa. With no grant it holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            if (w_wr_any) r_wptr <= w_wr_gnt[0];
            if (w_rd_any) r_rptr <= w_rd_gnt[0];
        end
    end

    // ------------------------------------------------------------------
    // Error flag
    // ------------------------------------------------------------------
    logic r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if ((w_wr_any && !w_wr_win_ok) || (w_rd_any && !w_rd_win_ok)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    // ------------------------------------------------------------------
    // Read response tracking
    // ------------------------------------------------------------------
    // One outstanding slot is enough: the RAM has fixed one-cycle latency and
    // responses cannot be back-pressured. Reset drops any pending response.
    logic r_resp_valid;
    logic r_resp_id;
    logic r_resp_oor;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_oor   <= 1'b0;
        end else begin
            r_resp_valid <= w_rd_any;
            r_resp_id    <= w_rd_gnt[1];
            r_resp_oor   <= !w_rd_win_ok;
        end
    end

    logic [DW-1:0] w_resp_data;
    logic [1:0]    w_rvalid;
    logic [DW-1:0] w_rdata [2];
    logic [DW-1:0] r_rdata_hold [2];

    // Out-of-range reads never touched the RAM, so ram_rd is stale for them.
    assign w_resp_data = r_resp_oor ? '0 : ram_rd;

    // Each reader sees live RAM data in its response cycle and otherwise the
    // last value it was given.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign w_rvalid[gi] = r_resp_valid && (r_resp_id == 1'(gi));
            assign w_rdata[gi]  = w_rvalid[gi] ? w_resp_data : r_rdata_hold[gi];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_rdata_hold[gi] <= '0;
                end else if (w_rvalid[gi]) begin
                    r_rdata_hold[gi] <= w_resp_data;
                end
            end
        end
    endgenerate

    assign rd0_rvalid = w_rvalid[0];
    assign rd1_rvalid = w_rvalid[1];
    assign rd0_rdata  = w_rdata[0];
    assign rd1_rdata  = w_rdata[1];

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dp_ram_arbiter
//
// Directed bench for dp_ram_arbiter with a behavioural read-before-write RAM
// attached to the RAM ports. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dp_ram_arbiter;

    localparam int DW    = 18;
    localparam int DEPTH = 360;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr0_valid, wr1_valid, rd0_valid, rd1_valid;
    logic          wr0_ready, wr1_ready, rd0_ready, rd1_ready;
    logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          rd0_rvalid, rd1_rvalid;
    logic [DW-1:0] rd0_rdata, rd1_rdata;
    logic          err;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [DW-1:0] ram_wd;
    logic [DW-1:0] ram_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dp_ram_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr0_valid  (wr0_valid),
        .wr0_ready  (wr0_ready),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_valid  (wr1_valid),
        .wr1_ready  (wr1_ready),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .rd0_valid  (rd0_valid),
        .rd0_ready  (rd0_ready),
        .rd0_addr   (rd0_addr),
        .rd0_rvalid (rd0_rvalid),
        .rd0_rdata  (rd0_rdata),
        .rd1_valid  (rd1_valid),
        .rd1_ready  (rd1_ready),
        .rd1_addr   (rd1_addr),
        .rd1_rvalid (rd1_rvalid),
        .rd1_rdata  (rd1_rdata),
        .err        (err),
        .ram_we     (ram_we),
        .ram_wa     (ram_wa),
        .ram_wd     (ram_wd),
        .ram_re     (ram_re),
        .ram_ra     (ram_ra),
        .ram_rd     (ram_rd)
    );

    // Behavioural RAM: registered read, old data on same-address collision.
    logic [DW-1:0] mem [512];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        ram_rd = '0;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        if (ram_re) ram_rd <= mem[ram_ra];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        rd0_valid = 1'b0;
        rd1_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset with every request asserted ----------------
        resetn    = 1'b0;
        wr0_valid = 1'b1; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b1; wr1_addr = '0; wr1_data = '0;
        rd0_valid = 1'b1; rd0_addr = '0;
        rd1_valid = 1'b1; rd1_addr = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_wr0_ready", 32'(wr0_ready), 0);
        chk("rst_wr1_ready", 32'(wr1_ready), 0);
        chk("rst_rd0_ready", 32'(rd0_ready), 0);
        chk("rst_rd1_ready", 32'(rd1_ready), 0);
        chk("rst_rvalid",    32'({rd1_rvalid, rd0_rvalid}), 0);
        chk("rst_rdata0",    32'(rd0_rdata), 0);
        chk("rst_ram_we",    32'(ram_we), 0);
        chk("rst_ram_re",    32'(ram_re), 0);
        chk("rst_err",       32'(err), 0);

        // Release: requester 0 wins on both ports.
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_wr0_ready", 32'(wr0_ready), 1);
        chk("rel_wr1_ready", 32'(wr1_ready), 0);
        chk("rel_rd0_ready", 32'(rd0_ready), 1);
        chk("rel_rd1_ready", 32'(rd1_ready), 0);
        step();
        idle();
        @(negedge clk);
        chk("rel_rd0_rvalid", 32'(rd0_rvalid), 1);
        chk("rel_rd1_rvalid", 32'(rd1_rvalid), 0);

        // ---------------- single writer then reader ----------------
        // wptr=1, rptr=1 here; lone requesters win anyway.
        step();
        wr1_valid = 1'b1; wr1_addr = 9'd17; wr1_data = 18'h2A5A5;
        @(negedge clk);
        chk("w1_ready",   32'(wr1_ready), 1);
        chk("w1_wr0_rdy", 32'(wr0_ready), 0);
        chk("w1_ram_we",  32'(ram_we), 1);
        chk("w1_ram_wa",  32'(ram_wa), 17);
        chk("w1_ram_wd",  32'(ram_wd), 32'h2A5A5);
        step();
        idle();
        @(negedge clk);
        chk("w1_ready_drop", 32'(wr1_ready), 0);
        step();
        rd1_valid = 1'b1; rd1_addr = 9'd17;
        @(negedge clk);
        chk("r1_ready",  32'(rd1_ready), 1);
        chk("r1_ram_re", 32'(ram_re), 1);
        chk("r1_ram_ra", 32'(ram_ra), 17);
        chk("r1_early",  32'(rd1_rvalid), 0);
        step();
        idle();
        @(negedge clk);
        chk("r1_rvalid",  32'(rd1_rvalid), 1);
        chk("r1_rdata",   32'(rd1_rdata), 32'h2A5A5);
        chk("r1_rd0_rv",  32'(rd0_rvalid), 0);
        step();
        @(negedge clk);
        chk("r1_rvalid_drop", 32'(rd1_rvalid), 0);
        chk("r1_rdata_hold",  32'(rd1_rdata), 32'h2A5A5);

        // ---------------- write contention (wptr=0) ----------------
        step();
        wr0_valid = 1'b1; wr0_addr = 9'd3; wr0_data = 18'h03333;
        wr1_valid = 1'b1; wr1_addr = 9'd4; wr1_data = 18'h04444;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wc%0d_wr0_ready", k), 32'(wr0_ready), 32'(k % 2 == 0));
            chk($sformatf("wc%0d_wr1_ready", k), 32'(wr1_ready), 32'(k % 2 == 1));
            chk($sformatf("wc%0d_ram_wa", k), 32'(ram_wa), (k % 2 == 0) ? 3 : 4);
            step();
        end

        // ---------------- read contention with concurrent writes ----------------
        rd0_valid = 1'b1; rd0_addr = 9'd3;
        rd1_valid = 1'b1; rd1_addr = 9'd4;
        wr0_addr = 9'd200; wr0_data = 18'h00001;
        wr1_addr = 9'd201; wr1_data = 18'h00002;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rc%0d_rd0_ready", k), 32'(rd0_ready), 32'(k % 2 == 0));
            chk($sformatf("rc%0d_rd1_ready", k), 32'(rd1_ready), 32'(k % 2 == 1));
            chk($sformatf("rc%0d_ram_ra", k), 32'(ram_ra), (k % 2 == 0) ? 3 : 4);
            chk($sformatf("rc%0d_wr0_ready", k), 32'(wr0_ready), 32'(k % 2 == 0));
            chk($sformatf("rc%0d_ram_we", k), 32'(ram_we), 1);
            if (k > 0) begin
                if ((k - 1) % 2 == 0) begin
                    chk($sformatf("rc%0d_rv", k), 32'({rd1_rvalid, rd0_rvalid}), 32'b01);
                    chk($sformatf("rc%0d_rd0_data", k), 32'(rd0_rdata), 32'h03333);
                end else begin
                    chk($sformatf("rc%0d_rv", k), 32'({rd1_rvalid, rd0_rvalid}), 32'b10);
                    chk($sformatf("rc%0d_rd1_data", k), 32'(rd1_rdata), 32'h04444);
                end
            end
            step();
        end
        idle();
        @(negedge clk);
        chk("rc_last_rv",      32'({rd1_rvalid, rd0_rvalid}), 32'b10);
        chk("rc_last_rd1",     32'(rd1_rdata), 32'h04444);
        chk("rc_rd0_hold",     32'(rd0_rdata), 32'h03333);
        chk("rc_err_clean",    32'(err), 0);

        // ---------------- same-address collision ----------------
        step();
        wr0_valid = 1'b1; wr0_addr = 9'd5; wr0_data = 18'h00011;
        step();
        wr0_data  = 18'h00022;
        rd0_valid = 1'b1; rd0_addr = 9'd5;
        @(negedge clk);
        chk("col_both", 32'({ram_re, ram_we}), 32'b11);
        step();
        wr0_valid = 1'b0;
        @(negedge clk);
        chk("col_old_rv",   32'(rd0_rvalid), 1);
        chk("col_old_data", 32'(rd0_rdata), 32'h00011);
        step();
        idle();
        @(negedge clk);
        chk("col_new_rv",   32'(rd0_rvalid), 1);
        chk("col_new_data", 32'(rd0_rdata), 32'h00022);

        // ---------------- out-of-range ----------------
        step();
        wr0_valid = 1'b1; wr0_addr = 9'd360; wr0_data = 18'h3FFFF;
        @(negedge clk);
        chk("oor_wr_ready", 32'(wr0_ready), 1);
        chk("oor_wr_we",    32'(ram_we), 0);
        chk("oor_err_pre",  32'(err), 0);
        step();
        idle();
        @(negedge clk);
        chk("oor_err_set", 32'(err), 1);
        step();
        rd0_valid = 1'b1; rd0_addr = 9'd511;
        @(negedge clk);
        chk("oor_rd_ready", 32'(rd0_ready), 1);
        chk("oor_rd_re",    32'(ram_re), 0);
        step();
        idle();
        @(negedge clk);
        chk("oor_rd_rv",   32'(rd0_rvalid), 1);
        chk("oor_rd_data", 32'(rd0_rdata), 0);
        step();
        step();
        @(negedge clk);
        chk("oor_err_sticky", 32'(err), 1);

        // ---------------- reset during an outstanding read ----------------
        step();
        rd0_valid = 1'b1; rd0_addr = 9'd3;
        @(negedge clk);
        chk("mr_rd0_ready", 32'(rd0_ready), 1);
        #2;
        resetn = 1'b0;
        idle();
        step();
        @(negedge clk);
        chk("mr_in_rst_rv", 32'({rd1_rvalid, rd0_rvalid}), 0);
        step();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mr_post%0d_rv", k), 32'({rd1_rvalid, rd0_rvalid}), 0);
            step();
        end
        @(negedge clk);
        chk("mr_err_cleared", 32'(err), 0);
        chk("mr_rdata0_clr",  32'(rd0_rdata), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
